// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared state type and default constants for the clock divider sequencer
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam int DEF_CNT_W  = 8;
    localparam int DEF_HALF   = 3;
    localparam int DEF_PCNT_W = 16;

endpackage

// File: rtl/clk_div_sequencer_if.sv
// rtl/clk_div_sequencer_if.sv - valid/ready configuration port of the clock divider sequencer
interface clk_div_sequencer_if
    import clk_div_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_half;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (output cfg_valid, output cfg_half, input cfg_ready, input cfg_err);
    modport slave  (input cfg_valid, input cfg_half, output cfg_ready, output cfg_err);
endinterface

// File: rtl/clk_div_core.sv
// rtl/clk_div_core.sv - half-period counter, clk_out toggle and full-period boundary detect
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int DEFAULT_HALF = DEF_HALF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             load,
    input  logic [CNT_W-1:0] load_half,
    output logic             clk_out,
    output logic             boundary
);
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] active_half;
    logic [CNT_W-1:0] last;
    logic             wrap;

    // active_half is never 0, so last never underflows
    assign last     = active_half - CNT_W'(1);
    assign wrap     = run && (count == last);
    assign boundary = wrap && clk_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            clk_out <= 1'b0;
        end else if (!run) begin
            count <= '0;
        end else if (wrap) begin
            count   <= '0;
            clk_out <= ~clk_out;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_half <= CNT_W'(DEFAULT_HALF);
        end else if (load) begin
            active_half <= load_half;
        end
    end
endmodule

// File: rtl/clk_div_sequencer.sv
// rtl/clk_div_sequencer.sv - glitch-free programmable clock divider; CLK_DIV_SEQ_PERIOD_CNT_EN adds period_count
module clk_div_sequencer
    import clk_div_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int DEFAULT_HALF = DEF_HALF
`ifdef CLK_DIV_SEQ_PERIOD_CNT_EN
    ,
    parameter int PCNT_W       = DEF_PCNT_W
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    clk_div_sequencer_if.slave  cfg,
    output logic                clk_out,
    output logic                running,
    output logic                period_done
`ifdef CLK_DIV_SEQ_PERIOD_CNT_EN
    ,
    output logic [PCNT_W-1:0]   period_count
`endif
);
    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] pending;
    logic             pending_valid;
    logic             boundary;
    logic             xfer;
    logic             xfer_ok;
    logic             load;
    logic [CNT_W-1:0] load_half;

    assign xfer          = cfg.cfg_valid && cfg.cfg_ready;
    assign xfer_ok       = xfer && (cfg.cfg_half != '0);
    assign cfg.cfg_ready = !pending_valid;
    assign running       = (state != IDLE);

    always_comb begin
        state_nx  = state;
        load      = 1'b0;
        load_half = pending;
        case (state)
            IDLE: begin
                if (en) state_nx = RUN;
                // a value accepted on the final boundary cycle lands here
                if (pending_valid) begin
                    load = 1'b1;
                end else if (xfer_ok) begin
                    load      = 1'b1;
                    load_half = cfg.cfg_half;
                end
            end
            RUN: begin
                if (!en) state_nx = boundary ? IDLE : STOPPING;
                load = boundary && pending_valid;
            end
            STOPPING: begin
                if (en) state_nx = RUN;
                else if (boundary) state_nx = IDLE;
                load = boundary && pending_valid;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pending       <= '0;
            pending_valid <= 1'b0;
            period_done   <= 1'b0;
            cfg.cfg_err   <= 1'b0;
        end else begin
            state       <= state_nx;
            period_done <= boundary;
            cfg.cfg_err <= xfer && (cfg.cfg_half == '0);
            if (load) pending_valid <= 1'b0;
            if (xfer_ok && (state != IDLE)) begin
                pending       <= cfg.cfg_half;
                pending_valid <= 1'b1;
            end
        end
    end

    clk_div_core #(
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (DEFAULT_HALF)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .run       (running),
        .load      (load),
        .load_half (load_half),
        .clk_out   (clk_out),
        .boundary  (boundary)
    );

`ifdef CLK_DIV_SEQ_PERIOD_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_count <= '0;
        end else if (period_done) begin
            period_count <= period_count + PCNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_clk_div_sequencer.sv
// tb/tb_clk_div_sequencer.sv - scoreboard bench for clk_div_sequencer
module tb_clk_div_sequencer;
    logic clk = 1'b0;
    logic reset;
    logic en;
    logic clk_out;
    logic running;
    logic period_done;
`ifdef CLK_DIV_SEQ_PERIOD_CNT_EN
    logic [15:0] period_count;
`endif

    clk_div_sequencer_if #(.CNT_W(8)) cfg_if ();

    clk_div_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .cfg          (cfg_if),
        .clk_out      (clk_out),
        .running      (running),
        .period_done  (period_done)
`ifdef CLK_DIV_SEQ_PERIOD_CNT_EN
        ,
        .period_count (period_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int low;
        int high;
    } period_t;

    period_t exp_q[$];
    int      err_q[$];
    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    int      periods_seen = 0;
    int      model_half;
    bit      mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: measures every completed clk_out period and every cfg_err pulse
    initial begin
        logic    prev_clk;
        int      low_cnt;
        int      high_cnt;
        bit      fall;
        period_t e;
        prev_clk = 1'b0;
        low_cnt  = 0;
        high_cnt = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_clk = 1'b0;
                low_cnt  = 0;
                high_cnt = 0;
            end else begin
                fall = prev_clk && !clk_out;
                if (fall || period_done) check("period_done_at_fall", period_done, fall);
                if (fall) begin
                    periods_seen++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_period", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("low_phase_len", low_cnt, e.low);
                        check("high_phase_len", high_cnt, e.high);
                    end
                    low_cnt  = 0;
                    high_cnt = 0;
                end
                if (running && !clk_out) low_cnt++;
                if (clk_out) high_cnt++;
                if (cfg_if.cfg_err) begin
                    if (err_q.size() == 0) check("unexpected_cfg_err", 1, 0);
                    else check("cfg_err_cycle", cyc, err_q.pop_front());
                end
                prev_clk = clk_out;
            end
        end
    end

    task automatic wait_rise();
        logic p;
        bit   ok;
        p  = clk_out;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (!p && clk_out) ok = 1'b1;
            p = clk_out;
        end
        if (!ok) check("rise_timeout", 0, 1);
    endtask

    task automatic idle_cfg(input int v);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_half  = 8'(v);
        if (v == 0) err_q.push_back(cyc + 1);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        check("cfg_ready_idle", cfg_if.cfg_ready, 1);
        if (v != 0) model_half = v;
    endtask

    // Run k periods; cfg_val (>=0) is offered in the high phase of period p_cfg and
    // governs every period after it; en drops drop_j cycles into the last high phase.
    task automatic scenario(input int k, input int p_cfg, input int cfg_val,
                            input int drop_j, input bit bounce);
        int h;
        int nh;
        int hk;
        int j;
        bit stopped;
        h  = model_half;
        nh = (cfg_val > 0) ? cfg_val : h;
        for (int p = 1; p <= k; p++) begin
            hk = (p > p_cfg) ? nh : h;
            exp_q.push_back('{hk, hk});
        end
        en = 1'b1;
        for (int p = 1; p <= k; p++) begin
            wait_rise();
            if (p == p_cfg + 1 && cfg_val > 0) check("cfg_ready_restored", cfg_if.cfg_ready, 1);
            if (p == p_cfg && cfg_val >= 0) begin
                j = $urandom_range(0, h - 2);
                repeat (j) @(negedge clk);
                cfg_if.cfg_valid = 1'b1;
                cfg_if.cfg_half  = 8'(cfg_val);
                if (cfg_val == 0) err_q.push_back(cyc + 1);
                @(negedge clk);
                cfg_if.cfg_valid = 1'b0;
                check("cfg_ready_after_offer", cfg_if.cfg_ready, (cfg_val == 0));
            end
        end
        hk = (k > p_cfg) ? nh : h;
        j  = (drop_j > hk - 1) ? hk - 1 : drop_j;
        repeat (j) @(negedge clk);
        en = 1'b0;
        if (bounce && j <= hk - 2) begin
            @(negedge clk);
            check("running_in_stopping", running, 1);
            en = 1'b1;
            exp_q.push_back('{hk, hk});
            wait_rise();
            en = 1'b0;
        end
        stopped = 1'b0;
        for (int n = 0; n < 200 && !stopped; n++) begin
            @(negedge clk);
            if (!running) stopped = 1'b1;
        end
        if (!stopped) check("stop_timeout", 0, 1);
        check("idle_clk_out_low", clk_out, 0);
        repeat (2) @(negedge clk);
        check("periods_outstanding", exp_q.size(), 0);
        if (cfg_val > 0) model_half = nh;
    endtask

    task automatic reset_midrun();
        en = 1'b1;
        wait_rise();
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_half  = 8'd7;
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        check("cfg_ready_pending", cfg_if.cfg_ready, 0);
        mon_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("reset_clk_out_low", clk_out, 0);
        check("reset_cfg_ready", cfg_if.cfg_ready, 1);
        check("reset_running", running, 0);
        exp_q.delete();
        err_q.delete();
        periods_seen = 0;
        en = 1'b0;
        @(negedge clk);
        reset      = 1'b0;
        model_half = 3;
        mon_en     = 1'b1;
        scenario(3, 0, -1, 0, 1'b0);
    endtask

    initial begin
        int k;
        int pc;
        int cv;
        reset            = 1'b1;
        en               = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_half  = '0;
        repeat (3) @(negedge clk);
        check("rst_clk_out", clk_out, 0);
        check("rst_running", running, 0);
        check("rst_period_done", period_done, 0);
        check("rst_cfg_ready", cfg_if.cfg_ready, 1);
        check("rst_cfg_err", cfg_if.cfg_err, 0);
        reset      = 1'b0;
        model_half = 3;
        mon_en     = 1'b1;
        @(negedge clk);

        scenario(3, 0, -1, 2, 1'b0);
        scenario(3, 1, 5, 0, 1'b0);
        idle_cfg(0);
        scenario(2, 1, 0, 1, 1'b0);
        idle_cfg(4);
        scenario(2, 0, -1, 1, 1'b0);
        scenario(2, 0, -1, 0, 1'b1);
        reset_midrun();

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 2) == 0) idle_cfg($urandom_range(0, 9));
            k  = $urandom_range(2, 4);
            pc = $urandom_range(1, k - 1);
            cv = (model_half >= 2 && $urandom_range(0, 1) == 1) ? $urandom_range(0, 9) : -1;
            scenario(k, pc, cv, $urandom_range(0, 8), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("cfg_err_outstanding", err_q.size(), 0);
`ifdef CLK_DIV_SEQ_PERIOD_CNT_EN
        check("period_count", period_count, periods_seen & 32'hffff);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/clk_div_sequencer.md
Name: clk_div_sequencer

Overview:
- Runtime-programmable clock divider controller: generates a divided clock whose half-period is set through a valid/ready configuration port.
- Applies new ratios and start/stop requests only at full output-period boundaries, so clk_out never has a runt pulse or truncated phase.
- Sits between the system register/config logic and downstream logic that consumes clk_out and period_done.

Parameters:
- CNT_W, 8, width of the half-period counter and configuration value.
- DEFAULT_HALF, 3, half-period in clk cycles loaded at reset. Must be 1..2^CNT_W-1.
- PCNT_W, 16, width of the period counter (optional feature only).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  level request to run the divided clock
- cfg_valid  in  1  new half-period offered
- cfg_half  in  CNT_W  requested half-period in clk cycles
- cfg_ready  out  1  high when the block can accept a configuration
- cfg_err  out  1  one-cycle pulse when an offered value is rejected
- clk_out  out  1  divided clock, registered
- running  out  1  high in RUN and STOPPING
- period_done  out  1  one-cycle pulse at each full-period boundary
- period_count  out  PCNT_W  completed periods (only with the optional feature)

Behaviour:
- Clock and reset:
  - Clock clk; reset is asynchronous and active-high.
  - Reset values: state=IDLE, count=0, clk_out=0, active_half=DEFAULT_HALF, pending_valid=0, cfg_ready=1, cfg_err=0, period_done=0, running=0, period_count=0.
  - Reset mid-operation forces clk_out low immediately and discards any pending value.
- Counter:
  - Counts 0..active_half-1 only in RUN and STOPPING. It is held at 0 in IDLE.
  - At count==active_half-1: count<=0 and clk_out<=~clk_out.
  - Output period is 2*active_half clk cycles at 50% duty.
- Boundary: the cycle with count==active_half-1 and clk_out==1 (the falling toggle). On that cycle:
  - period_done is asserted on the next cycle for 1 cycle.
  - If pending_valid, then active_half<=pending and pending_valid<=0.
- FSM:
  - IDLE: clk_out=0. If en=1, go to RUN. count starts at 0, so clk_out rises active_half cycles after entering RUN.
  - RUN: if en=0 before the boundary, go to STOPPING. If en=0 on the boundary cycle, go to IDLE.
  - STOPPING: the current period completes unchanged. If en=1, return to RUN with no disturbance. At the boundary, go to IDLE, with clk_out ending low.
- Config handshake:
  - A transfer happens when cfg_valid && cfg_ready.
  - cfg_half==0: rejected. cfg_err pulses for 1 cycle, no state changes, cfg_ready stays 1.
  - In IDLE: active_half<=cfg_half on the next edge and cfg_ready stays 1. If en is also high, RUN starts using the new value.
  - In RUN/STOPPING: the value is stored in pending, pending_valid<=1 and cfg_ready<=0. cfg_ready returns to 1 on the cycle after the applying boundary.
  - A transfer accepted in a boundary cycle waits for the following boundary.
  - A pending value still held on the STOPPING->IDLE boundary is applied at that boundary.
- Width rules:
  - The comparison uses active_half-1 at CNT_W bits. A value of 0 can never reach active_half.
  - period_count wraps modulo 2^PCNT_W.

Optional Feature:
- Macro: CLK_DIV_SEQ_PERIOD_CNT_EN.
- Defined: the period_count port exists and increments on every period_done. It is cleared only by reset.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Package clk_div_pkg:
  - State typedef (IDLE, RUN, STOPPING).
  - DEFAULT_HALF and CNT_W default constants.
- One sub-module, clk_div_core:
  - Contains count, clk_out toggle and boundary detect.
  - Has a load input for active_half.
- clk_div_sequencer holds the FSM, pending register and handshake.

Test Plan:
- Reset release, en=1, no config -> clk_out rises 3 cycles after RUN entry. Period is 6 cycles. period_done fires every 6 cycles. running=1.
- Running with H=3, offer cfg_half=5 mid-high-phase -> cfg_ready drops the next cycle. The current low/high phases stay at 3. The following high phase lasts 5 cycles. cfg_ready returns 1 after the boundary.
- Offer cfg_half=0 in both IDLE and RUN -> 1-cycle cfg_err pulse, ratio unchanged, cfg_ready stays 1.
- Drop en 1 cycle into a high phase (H=4) -> state STOPPING, high phase lasts a full 4 cycles, clk_out falls at the boundary, IDLE, running=0, no runt.
- In STOPPING, reassert en before the boundary -> returns to RUN, period length unchanged, no gap in clk_out.
- Assert reset mid-high-phase with a pending value of 7 -> clk_out=0 immediately. After release with en=1, period is 6 (DEFAULT_HALF) and the pending value is discarded.
